rs232_tx_fifo: RTL and testbench
================================

RS232_TX_FIFO -- requirements
Module: rs232_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter DIV_W, default 16, width of the baud divisor input.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports listed clock and reset first.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 div  input  DIV_W  clocks per bit minus one; div=0 gives 1 clock per bit.
REQ-008 stop2  input  1  1: two stop bits; 0: one stop bit.
REQ-009 par_odd  input  1  1: odd parity; 0: even parity; used only when parity is compiled in.
REQ-010 val  input  1  write request for bits.
REQ-011 bits  input  DATA_W  character to enqueue.
REQ-012 rdy  output  1  FIFO can accept a character this cycle.
REQ-013 TxD  output  1  serial line; idle high.
REQ-014 level  output  log2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-015 busy  output  1  FIFO non-empty or frame in progress.

Function
REQ-016 A push SHALL occur exactly on a cycle where val && rdy; rdy SHALL equal (level != FIFO_DEPTH), combinational from registered state.
REQ-017 Serializer FSM states SHALL be IDLE, START, DATA, PAR, STOP.
REQ-018 Every state except IDLE SHALL hold for div+1 clocks per bit; div, stop2 and par_odd SHALL be latched at pop and held for the whole frame.
REQ-019 In IDLE with level != 0, the FSM SHALL pop the head entry and enter START; TxD SHALL go low on the following cycle.
REQ-020 START drives 0 for one bit, then DATA.
REQ-021 DATA drives the latched character LSB first, DATA_W bits, then PAR if parity is compiled in, else STOP.
REQ-022 PAR drives the XOR of the data bits, inverted when the latched par_odd=1.
REQ-023 STOP drives 1 for one bit (stop2=0) or two bits (stop2=1).
REQ-024 On the last clock of STOP, with level != 0, the FSM SHALL pop and enter START directly, giving zero idle clocks between frames; otherwise it enters IDLE.
REQ-025 TxD SHALL be registered, with no combinational path from any input.
REQ-026 On a simultaneous push and pop, level SHALL be unchanged and both operations take effect.
REQ-027 A push into an empty FIFO while IDLE SHALL be popped on the next cycle; the start bit begins 2 clocks after the push edge.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the full/empty distinction comes from level.
REQ-029 busy SHALL equal (state != IDLE) || (level != 0).
REQ-030 A change of div mid-frame SHALL NOT affect the current frame.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately, and regardless of clk, force: TxD=1, state=IDLE, level=0, pointers=0, bit counter=0, rdy=1, busy=0.
REQ-032 Reset mid-frame SHALL abort the frame and discard all queued characters; the line stays high.
REQ-033 Deassertion of rst_n is expected synchronous to clk; FIFO storage contents are not reset.

Configuration
REQ-034 Macro RS232_TX_PARITY_EN: when defined, the PAR state and the par_odd input are active and a frame is 1+DATA_W+1+stop bits.
REQ-035 Without RS232_TX_PARITY_EN, the PAR state and its logic SHALL be absent, par_odd is ignored, and a frame is 1+DATA_W+stop bits.

Verification
REQ-036 div=3, stop2=0, no parity, push 0x55 -> TxD low 4 clocks starting 2 clocks after push, then bits 1,0,1,0,1,0,1,0 at 4 clocks each, then high 4 clocks; busy falls after the stop bit.
REQ-037 FIFO_DEPTH=4, hold val=1 with 6 characters while TX is active -> rdy low when level=4; 6 frames emitted back-to-back with no idle clocks, in order.
REQ-038 Parity on, par_odd=1, push 0x07 -> parity bit 0; par_odd=0 -> parity bit 1.
REQ-039 stop2=1, div=0, push 0xFF then 0x00 -> 2 high stop clocks between frames; frame length 11 clocks without parity.
REQ-040 Reset pulsed mid-DATA with 3 entries queued -> TxD=1 and level=0 immediately; nothing further transmitted.
REQ-041 Change div from 3 to 7 mid-frame -> current frame keeps 4-clock bits; the next frame uses 8-clock bits.

Source files
------------

// File: rtl/rs232_tx_fifo.sv
// rs232_tx_fifo: transmit FIFO feeding an RS-232 serializer.
// Build option: define RS232_TX_PARITY_EN to include the parity bit (PAR state
// and the par_odd input). Without it, frames are start + data + stop(s).
//
// state | meaning
// IDLE  | line idle high, waiting for a queued character
// START | start bit, line low
// DATA  | character bits, LSB first
// PAR   | parity bit (only with RS232_TX_PARITY_EN)
// STOP  | one or two stop bits, line high
module rs232_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              div,
  input  logic                          stop2,
  input  logic                          par_odd,
  input  logic                          val,
  input  logic [DATA_W-1:0]             bits,
  output logic                          rdy,
  output logic                          TxD,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(DATA_W);

`ifdef RS232_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [DIV_W-1:0]  div_lat_q, div_lat_d;
  logic              stop2_lat_q, stop2_lat_d;
  logic              txd_q, txd_d;
  logic              push;
  logic              pop;
  logic              bit_tick;
`ifdef RS232_TX_PARITY_EN
  logic              par_bit_q, par_bit_d;
`else
  logic              unused_par_odd;
  assign unused_par_odd = par_odd;
`endif

  assign push     = val && rdy;
  assign bit_tick = (baud_cnt_q == '0);

  // Next-state, FIFO pointer/level and line-value computation.
  always_comb begin
    pop         = 1'b0;
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    baud_cnt_d  = baud_cnt_q;
    div_lat_d   = div_lat_q;
    stop2_lat_d = stop2_lat_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    txd_d       = 1'b1;
`ifdef RS232_TX_PARITY_EN
    par_bit_d   = par_bit_q;
`endif

    // Bit timer reloads from the divisor latched for this frame.
    if (state_q != IDLE) begin
      baud_cnt_d = bit_tick ? div_lat_q : (baud_cnt_q - DIV_W'(1));
    end

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (level_q != '0) pop = 1'b1;
      end
      START: begin
        txd_d = 1'b0;
        if (bit_tick) begin
          state_d   = DATA;
          bit_cnt_d = CNT_W'(DATA_W - 1);
        end
      end
      DATA: begin
        txd_d = shift_q[0];
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == '0) begin
`ifdef RS232_TX_PARITY_EN
            state_d = PAR;
`else
            state_d   = STOP;
            bit_cnt_d = {{(CNT_W-1){1'b0}}, stop2_lat_q};
`endif
          end else begin
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
          end
        end
      end
`ifdef RS232_TX_PARITY_EN
      PAR: begin
        txd_d = par_bit_q;
        if (bit_tick) begin
          state_d   = STOP;
          bit_cnt_d = {{(CNT_W-1){1'b0}}, stop2_lat_q};
        end
      end
`endif
      STOP: begin
        txd_d = 1'b1;
        if (bit_tick) begin
          if (bit_cnt_q != '0) begin
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
          end else if (level_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A pop loads the head character and freezes the frame configuration.
    if (pop) begin
      state_d     = START;
      shift_d     = mem_q[rd_ptr_q];
      bit_cnt_d   = '0;
      baud_cnt_d  = div;
      div_lat_d   = div;
      stop2_lat_d = stop2;
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
`ifdef RS232_TX_PARITY_EN
      par_bit_d   = (^mem_q[rd_ptr_q]) ^ par_odd;
`endif
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  // FIFO storage is intentionally not reset; level alone defines validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bits;
  end

  // Control state with asynchronous reset; TxD is registered one clock behind the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      baud_cnt_q  <= '0;
      div_lat_q   <= '0;
      stop2_lat_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      txd_q       <= 1'b1;
`ifdef RS232_TX_PARITY_EN
      par_bit_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      baud_cnt_q  <= baud_cnt_d;
      div_lat_q   <= div_lat_d;
      stop2_lat_q <= stop2_lat_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      txd_q       <= txd_d;
`ifdef RS232_TX_PARITY_EN
      par_bit_q   <= par_bit_d;
`endif
    end
  end

  assign rdy   = (level_q != LVL_W'(FIFO_DEPTH));
  assign TxD   = txd_q;
  assign level = level_q;
  assign busy  = (state_q != IDLE) || (level_q != '0);

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// Testbench for rs232_tx_fifo: random and directed traffic checked every clock
// against a queue-based line model (character queue + per-clock frame waveform).
module tb_rs232_tx_fifo;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DIV_W-1:0]  div = '0;
  logic              stop2 = 1'b0;
  logic              par_odd = 1'b0;
  logic              val = 1'b0;
  logic [DATA_W-1:0] bits = '0;
  logic              rdy;
  logic              TxD;
  logic [LVL_W-1:0]  level;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model: queued characters, and the per-clock line value of the frame in flight.
  logic [DATA_W-1:0] m_fifo[$];
  bit                m_line[$];
  bit                m_txd = 1'b1;

  int  sent, n;
  bit  acc, saw_full;

  rs232_tx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .div(div), .stop2(stop2), .par_odd(par_odd),
    .val(val), .bits(bits), .rdy(rdy), .TxD(TxD), .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expand one character into its line waveform, div+1 clocks per bit.
  function automatic void model_add_frame(input logic [DATA_W-1:0] c, input int d, input bit s2);
    bit fb[$];
    fb.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) fb.push_back(c[i]);
`ifdef RS232_TX_PARITY_EN
    fb.push_back((^c) ^ par_odd);
`endif
    fb.push_back(1'b1);
    if (s2) fb.push_back(1'b1);
    foreach (fb[i]) repeat (d + 1) m_line.push_back(fb[i]);
  endfunction

  // One clock: advance the model with pre-edge inputs, then compare after the edge.
  task automatic tick();
    bit do_push, do_pop;
    do_push = val && (m_fifo.size() != FIFO_DEPTH);
    do_pop  = (m_line.size() <= 1) && (m_fifo.size() != 0);
    m_txd   = (m_line.size() != 0) ? m_line[0] : 1'b1;
    if (m_line.size() != 0) void'(m_line.pop_front());
    if (do_pop) model_add_frame(m_fifo.pop_front(), int'(div), stop2);
    if (do_push) m_fifo.push_back(bits);
    @(posedge clk);
    @(negedge clk);
    chk("txd", TxD, m_txd);
    chk("level", level, m_fifo.size());
    chk("rdy", rdy, m_fifo.size() != FIFO_DEPTH);
    chk("busy", busy, (m_line.size() != 0) || (m_fifo.size() != 0));
  endtask

  task automatic push_char(input logic [DATA_W-1:0] c);
    int w = 0;
    bits = c;
    val  = 1'b1;
    while (m_fifo.size() == FIFO_DEPTH && w < 2000) begin
      tick();
      w++;
    end
    tick();
    val = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int w = 0;
    val = 1'b0;
    while ((m_line.size() != 0 || m_fifo.size() != 0) && w < max_cycles) begin
      tick();
      w++;
    end
    tick();
    chk("drain_busy", busy, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_txd"}, TxD, 1'b1);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_rdy"}, rdy, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    // Reset acts without a clock edge.
    #2 rst_n = 1'b0;
    #1 check_reset_values("rst0");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single 0x55 at 4 clocks per bit, one stop bit.
    div = 16'd3; stop2 = 1'b0;
    push_char(8'h55);
    drain(500);

    // Two stop bits, 1 clock per bit, back-to-back frames.
    div = 16'd0; stop2 = 1'b1;
    push_char(8'hFF);
    push_char(8'h00);
    drain(500);

`ifdef RS232_TX_PARITY_EN
    div = 16'd1; stop2 = 1'b0;
    par_odd = 1'b1;
    push_char(8'h07);
    drain(500);
    par_odd = 1'b0;
    push_char(8'h07);
    drain(500);
`endif

    // Hold val with six characters: FIFO fills, frames run back-to-back.
    div = 16'd1; stop2 = 1'b0;
    sent = 0; n = 0; saw_full = 1'b0;
    val = 1'b1;
    while (sent < 6 && n < 1000) begin
      bits = 8'hA0 + DATA_W'(sent);
      acc  = (m_fifo.size() != FIFO_DEPTH);
      tick();
      if (acc) sent++;
      if (!rdy) saw_full = 1'b1;
      n++;
    end
    val = 1'b0;
    chk("full_rdy_low_seen", saw_full, 1'b1);
    drain(2000);

    // Divisor change mid-frame affects only the following frame.
    div = 16'd3; stop2 = 1'b0;
    push_char(8'hC3);
    repeat (10) tick();
    div = 16'd7;
    push_char(8'h3C);
    drain(1000);

    // Randomized traffic and configuration.
    for (int cyc = 0; cyc < 2500; cyc++) begin
      if (cyc % 64 == 0) begin
        div     = DIV_W'($urandom_range(0, 3));
        stop2   = 1'($urandom_range(0, 1));
        par_odd = 1'($urandom_range(0, 1));
      end
      val  = ($urandom_range(0, 3) == 0);
      bits = DATA_W'($urandom);
      tick();
    end
    drain(4000);

    // Reset mid-DATA with three characters queued.
    div = 16'd3; stop2 = 1'b0;
    push_char(8'h11);
    push_char(8'h22);
    push_char(8'h33);
    push_char(8'h44);
    repeat (6) tick();
    chk("pre_reset_level", level, 3);
    #2 rst_n = 1'b0;
    #1 check_reset_values("rst_mid");
    m_fifo.delete();
    m_line.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) tick();
    check_reset_values("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
